// File: rtl/train_sequencer.sv
// Step sequencer for a train/lap controller: walks STEP 0..15, advancing each step
// once the selected condition Y has been stable for DEBOUNCE WAIT cycles.
module train_sequencer #(
  parameter int unsigned TIMER_CYCLES = 50000000,
  parameter int unsigned DEBOUNCE     = 4,
  parameter bit          LOOP         = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       STOP,
  input  logic       Y,
  output logic [3:0] Selector,
  output logic       Enable,
  output logic       TIMER,
  output logic       BUSY,
  output logic       LAP_DONE
);
  typedef enum logic [1:0] {IDLE, SETTLE, WAIT} state_t;

  localparam logic [31:0] TC      = 32'(TIMER_CYCLES);
  localparam logic [3:0]  DB_LAST = 4'(DEBOUNCE - 1);

  state_t      state;
  logic [3:0]  step;
  logic [3:0]  dbCnt;
  logic [31:0] tmrCnt;
  logic [31:0] tmrInc;
  logic        timedStep;
  logic        advance;

  assign Selector  = step;
  assign timedStep = (step >= 4'd2) && (step <= 4'd5);
  // The debounce count is one behind: the cycle that would reach DEBOUNCE is the advance edge.
  assign advance   = (state == WAIT) && Y && (dbCnt == DB_LAST);
  assign tmrInc    = (tmrCnt == TC) ? tmrCnt : tmrCnt + 32'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      step     <= 4'd0;
      dbCnt    <= 4'd0;
      tmrCnt   <= 32'd0;
      Enable   <= 1'b0;
      TIMER    <= 1'b0;
      BUSY     <= 1'b0;
      LAP_DONE <= 1'b0;
    end else begin
      LAP_DONE <= 1'b0;
      if (STOP) begin
        state  <= IDLE;
        step   <= 4'd0;
        dbCnt  <= 4'd0;
        tmrCnt <= 32'd0;
        Enable <= 1'b0;
        TIMER  <= 1'b0;
        BUSY   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            step   <= 4'd0;
            dbCnt  <= 4'd0;
            tmrCnt <= 32'd0;
            TIMER  <= 1'b0;
            Enable <= 1'b0;
            if (START) begin
              state <= SETTLE;
              BUSY  <= 1'b1;
            end
          end
          SETTLE: begin
            dbCnt  <= 4'd0;
            tmrCnt <= 32'd0;
            TIMER  <= 1'b0;
            Enable <= 1'b1;
            state  <= WAIT;
          end
          WAIT: begin
            if (advance) begin
              step   <= step + 4'd1;
              dbCnt  <= 4'd0;
              tmrCnt <= 32'd0;
              TIMER  <= 1'b0;
              Enable <= 1'b0;
              state  <= SETTLE;
              if (step == 4'd15) begin
                LAP_DONE <= 1'b1;
                if (!LOOP) begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
                end
              end
            end else begin
              dbCnt <= Y ? dbCnt + 4'd1 : 4'd0;
              if (timedStep) begin
                tmrCnt <= tmrInc;
                TIMER  <= (tmrInc == TC);
              end else begin
                tmrCnt <= 32'd0;
                TIMER  <= 1'b0;
              end
            end
          end
          default: begin
            state  <= IDLE;
            Enable <= 1'b0;
            BUSY   <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
